// File: rtl/sub_pipe_t12.sv
// Clocked WIDTH-bit subtractor with borrow-in/borrow-out, delayed through a
// LATENCY-stage valid/ready pipeline whose empty stages collapse under stall.
module sub_pipe_t12 #(
    parameter int unsigned WIDTH   = 4,
    parameter int unsigned LATENCY = 3,
    parameter int unsigned CNTW    = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bi,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bo,
    output logic             ovf,
    output logic [CNTW-1:0]  occ
);
    localparam int unsigned LAST = LATENCY - 1;

    logic [LATENCY-1:0]            r_vld;
    logic [LATENCY-1:0][WIDTH-1:0] r_diff;
    logic [LATENCY-1:0]            r_bo;
    logic [LATENCY-1:0]            r_ovf;
    logic [CNTW-1:0]               r_occ;

    logic [LATENCY-1:0]            w_load;
    logic [LATENCY-1:0]            w_src_vld;
    logic [LATENCY-1:0][WIDTH-1:0] w_src_diff;
    logic [LATENCY-1:0]            w_src_bo;
    logic [LATENCY-1:0]            w_src_ovf;
    logic [LATENCY-1:0]            w_nxt_vld;
    logic [LATENCY-1:0][WIDTH-1:0] w_nxt_diff;
    logic [LATENCY-1:0]            w_nxt_bo;
    logic [LATENCY-1:0]            w_nxt_ovf;
    logic [WIDTH:0]                w_wide;
    logic                          w_ovf;
    logic                          w_in_xfer;
    logic                          w_out_xfer;

    // Wide subtraction: the extra MSB is the borrow-out.
    always_comb begin
        w_wide = {1'b0, a} - {1'b0, b} - (WIDTH + 1)'(bi);
        w_ovf  = (a[WIDTH-1] != b[WIDTH-1]) && (w_wide[WIDTH-1] != a[WIDTH-1]);
    end

    for (genvar i = 0; i < LATENCY; i++) begin : g_stage
        // A stage is blocked only when it and every stage ahead are full and the output stalls.
        assign w_load[i] = out_ready || !(&r_vld[LAST:i]);

        if (i == 0) begin : g_head
            assign w_src_vld[i]  = in_valid;
            assign w_src_diff[i] = in_valid ? w_wide[WIDTH-1:0] : '0;
            assign w_src_bo[i]   = in_valid && w_wide[WIDTH];
            assign w_src_ovf[i]  = in_valid && w_ovf;
        end else begin : g_body
            assign w_src_vld[i]  = r_vld[i-1];
            assign w_src_diff[i] = r_diff[i-1];
            assign w_src_bo[i]   = r_bo[i-1];
            assign w_src_ovf[i]  = r_ovf[i-1];
        end

        // Loading pulls in the upstream stage, so a drained stage picks up zeros.
        assign w_nxt_vld[i]  = w_load[i] ? w_src_vld[i]  : r_vld[i];
        assign w_nxt_diff[i] = w_load[i] ? w_src_diff[i] : r_diff[i];
        assign w_nxt_bo[i]   = w_load[i] ? w_src_bo[i]   : r_bo[i];
        assign w_nxt_ovf[i]  = w_load[i] ? w_src_ovf[i]  : r_ovf[i];
    end

    assign w_in_xfer  = in_valid && w_load[0];
    assign w_out_xfer = r_vld[LAST] && out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vld  <= '0;
            r_diff <= '0;
            r_bo   <= '0;
            r_ovf  <= '0;
            r_occ  <= '0;
        end else begin
            r_vld  <= w_nxt_vld;
            r_diff <= w_nxt_diff;
            r_bo   <= w_nxt_bo;
            r_ovf  <= w_nxt_ovf;
            r_occ  <= r_occ + CNTW'(w_in_xfer) - CNTW'(w_out_xfer);
        end
    end

    assign in_ready  = w_load[0];
    assign out_valid = r_vld[LAST];
    assign diff      = r_diff[LAST];
    assign bo        = r_bo[LAST];
    assign ovf       = r_ovf[LAST];
    assign occ       = r_occ;

endmodule
